branch_predictor: RTL
=====================

# branch_predictor

Fetch-stage branch predictor: a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Fetch queries it with the current PC and gets a same-cycle taken/target prediction.
- The execute-stage branch condition unit reports the resolved outcome back through the update port.
- The block then trains its tables and, on a misprediction, raises a registered one-cycle redirect toward fetch and the ROB flush logic.

## Interface
Parameters:
- BTB_ENTRIES, 16, number of BTB entries; power of two. IDX_BITS = log2(BTB_ENTRIES).
- TAG_BITS, 8, stored PC tag width.

Ports:
- clock  in  1  system clock. One clock domain.
- reset  in  1  synchronous, active-high reset.
- if_pc  in  XLEN  fetch PC to predict.
- pred_hit  out  1  tag match on a valid entry (combinational).
- pred_taken  out  1  pred_hit && counter[1].
- pred_target  out  XLEN  stored target when pred_taken, else if_pc+4.
- ex_valid  in  1  resolved control-flow instruction this cycle.
- ex_uncond  in  1  JAL/JALR; always treated as taken.
- ex_pc  in  XLEN  PC of the resolved instruction.
- ex_taken  in  1  brcond result (ignored when ex_uncond=1).
- ex_target  in  XLEN  computed target address.
- ex_pred_taken  in  1  prediction carried with the instruction.
- ex_pred_target  in  XLEN  predicted target carried with the instruction.
- redirect_valid  out  1  registered misprediction pulse.
- redirect_pc  out  XLEN  correct next PC.

## Operation
Indexing and tags:
- idx = pc[IDX_BITS+1:2]; tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- Each entry holds valid, tag, target and a 2-bit counter.

Lookup is purely combinational from the current state.

Resolved direction: actual = ex_uncond | ex_taken.

Update on ex_valid, applied at the clock edge:
- Hit, actual=1: counter saturating increment (max 11); target <= ex_target.
- Hit, actual=0: counter saturating decrement (min 00).
- Miss, actual=1: allocate the entry with valid=1, the new tag, target <= ex_target, counter=10.
- Miss, actual=0: no change.
- Unconditional hits set the counter to 11.

Mispredict is detected when ex_valid and (actual != ex_pred_taken, or actual && ex_target != ex_pred_target). On the next cycle:
- redirect_valid=1 for exactly one cycle.
- redirect_pc = actual ? ex_target : ex_pc+4.

All arithmetic is XLEN-bit unsigned; ex_pc+4 wraps modulo 2^XLEN.

## Timing
- Lookup latency is 0 cycles.
- Table update is visible to lookup one cycle after ex_valid.
- Redirect latency is 1 cycle after ex_valid.
- Lookup and update to the same index in the same cycle: lookup returns pre-update state. There is no bypass.
- Back-to-back updates to the same entry accumulate, one step per cycle.
- Reset values:
  - all valid bits 0; all counters 01.
  - redirect_valid=0, redirect_pc=0, GHR=0.
  - outputs out of reset: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
- Reset asserted together with ex_valid: reset wins; no update and no redirect.
- Reset asserted mid-stream clears a pending redirect on that edge.

## Configuration
BP_GSHARE_EN:
- Defined:
  - adds an IDX_BITS-wide global history register.
  - counter index = idx ^ GHR; BTB tag/target remain indexed by idx alone.
  - GHR shifts in `actual` on each ex_valid with ex_uncond=0; GHR reset value 0.
  - Lookup and update use the GHR value current in that cycle.
- Undefined: the counter index equals idx and no GHR exists.

## Structure
Shared package holds:
- btb_entry_t struct (valid, tag, target).
- the 2-bit counter typedef.
- localparams for counter constants: SNT=00, WNT=01, WT=10, ST=11.

One sub-module, sat_counter2: combinational next-state for the saturating counter, taking inc/dec/force_strong. It is instantiated in the update path.

## Test plan
- Reset, then if_pc=0x100 → pred_hit=0, pred_taken=0, pred_target=0x104.
- Taken branch ex_pc=0x100, ex_target=0x200, ex_pred_taken=0 → next cycle redirect_valid=1, redirect_pc=0x200. Lookup 0x100 then gives hit, taken, target 0x200.
- Same branch resolved not-taken three times from counter 10 → counter goes 01, 00, 00 (saturates); pred_taken=0. Each resolution with ex_pred_taken=1 yields redirect_pc=0x104.
- Aliasing: 0x100 allocated, then taken ex_pc=0x140 (BTB_ENTRIES=16, same idx, different tag) → entry replaced. Lookup 0x100 misses.
- Same-cycle lookup and update at 0x100 → lookup shows old state and the new state appears the following cycle. Reset asserted with ex_valid → no redirect, table cleared.
- BP_GSHARE_EN: two resolutions at 0x100 with GHR=0000 then 0001 → distinct counters are trained. Verify with a history-dependent alternating pattern whose prediction matches after warm-up.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared types and constants for the BTB branch predictor
package branch_predictor_pkg;
    localparam int XLEN = 32;
    typedef logic [1:0] ctr_t;
    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;
    // tag is held XLEN wide; only the low TAG_BITS are ever non-zero
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] target;
    } btb_entry_t;
endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating direction counter
//   ctr          current counter
//   inc/dec      saturating step up/down
//   force_strong jump straight to strongly-taken (wins over inc/dec)
//   nxt          next counter value
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    input  logic       dec,
    input  logic       force_strong,
    output logic [1:0] nxt
);
    assign nxt = force_strong ? ST :
                 inc ? (ctr == ST ? ST : ctr + 2'd1) :
                 dec ? (ctr == SNT ? SNT : ctr - 2'd1) : ctr;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters and registered mispredict redirect
//   clock, reset                 clock, synchronous active-high reset
//   if_pc                        fetch PC; pred_hit/pred_taken/pred_target same-cycle prediction
//   ex_valid, ex_uncond, ex_pc,  resolved control-flow instruction from execute,
//   ex_taken, ex_target,         with the prediction it carried
//   ex_pred_taken, ex_pred_target
//   redirect_valid, redirect_pc  one-cycle redirect one clock after a mispredict
// Optional BP_GSHARE_EN: counters indexed by idx ^ global history register.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    parameter int TAG_BITS    = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_uncond,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    localparam int IDX_BITS = $clog2(BTB_ENTRIES);

    btb_entry_t          btb  [BTB_ENTRIES];
    ctr_t                ctrs [BTB_ENTRIES];
    logic [IDX_BITS-1:0] l_idx, u_idx, l_cidx, u_cidx;
    logic [XLEN-1:0]     l_tag, u_tag;
    logic                actual, u_hit, mispred;
    ctr_t                ctr_nxt;

    assign l_idx  = if_pc[IDX_BITS+1:2];
    assign u_idx  = ex_pc[IDX_BITS+1:2];
    assign l_tag  = XLEN'(if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]);
    assign u_tag  = XLEN'(ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]);
    assign actual = ex_uncond | ex_taken;

`ifdef BP_GSHARE_EN
    logic [IDX_BITS-1:0] ghr;
    assign l_cidx = l_idx ^ ghr;
    assign u_cidx = u_idx ^ ghr;
    always_ff @(posedge clock) begin
        if (reset)
            ghr <= '0;
        else if (ex_valid && !ex_uncond)
            ghr <= IDX_BITS'({ghr, actual});
    end
`else
    assign l_cidx = l_idx;
    assign u_cidx = u_idx;
`endif

    assign pred_hit    = btb[l_idx].valid && btb[l_idx].tag == l_tag;
    assign pred_taken  = pred_hit && ctrs[l_cidx][1];
    assign pred_target = pred_taken ? btb[l_idx].target : if_pc + XLEN'(4);

    assign u_hit   = btb[u_idx].valid && btb[u_idx].tag == u_tag;
    assign mispred = ex_valid && (actual != ex_pred_taken || (actual && ex_target != ex_pred_target));

    sat_counter2 u_ctr (
        .ctr         (ctrs[u_cidx]),
        .inc         (actual),
        .dec         (!actual),
        .force_strong(ex_uncond),
        .nxt         (ctr_nxt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i]  <= '0;
                ctrs[i] <= WNT;
            end
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            if (ex_valid && u_hit) begin
                ctrs[u_cidx] <= ctr_nxt;
                if (actual)
                    btb[u_idx].target <= ex_target;
            end else if (ex_valid && actual) begin
                btb[u_idx]   <= '{valid: 1'b1, tag: u_tag, target: ex_target};
                ctrs[u_cidx] <= WT;
            end
            redirect_valid <= mispred;
            if (mispred)
                redirect_pc <= actual ? ex_target : ex_pc + XLEN'(4);
        end
    end
endmodule
